wb_arbiter: RTL and testbench

Arbitrates the result ports of the EXE-stage functional units (load, div, mul, alu, falu, ...) onto the single forwarding/writeback bus. Each port has a one-entry holding slot, so a unit that loses arbitration can retire its result and accept new work. Selection is fixed-priority with starvation escalation. Mispredict flushes drop squashed results. Drives a combinational forwarding bus and a registered WB bus to the ROB/PRF.

---
 rtl/wb_arbiter_if.sv | 42 ++++
 rtl/wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the FU result ports, the flush input and both output buses of wb_arbiter.
// Ports: req_* (port i in slice i), flush_valid/flush_mask, grant, ex_out_* (combinational), wb_out_* (registered).
// Modports: slave = arbiter side, master = FU/ROB side (drives requests and flushes, observes the buses).
interface wb_arbiter_if #(
  parameter int NUM_REQ = 6,
  parameter int ROB_LEN = 16,
  parameter int DATA_W  = 32,
  parameter int RD_W    = 7
);
  localparam int IDX_W = $clog2(ROB_LEN);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*IDX_W-1:0]  req_rob_idx;
  logic [NUM_REQ*RD_W-1:0]   req_rd;
  logic                      flush_valid;
  logic [ROB_LEN-1:0]        flush_mask;
  logic [NUM_REQ-1:0]        grant;
  logic                      ex_out_valid;
  logic [DATA_W-1:0]         ex_out_data;
  logic [IDX_W-1:0]          ex_out_rob_idx;
  logic [RD_W-1:0]           ex_out_rd;
  logic                      wb_out_valid;
  logic [DATA_W-1:0]         wb_out_data;
  logic [IDX_W-1:0]          wb_out_rob_idx;
  logic [RD_W-1:0]           wb_out_rd;

  modport slave (
    input  req_valid, req_data, req_rob_idx, req_rd, flush_valid, flush_mask,
    output req_ready, grant,
    output ex_out_valid, ex_out_data, ex_out_rob_idx, ex_out_rd,
    output wb_out_valid, wb_out_data, wb_out_rob_idx, wb_out_rd
  );

  modport master (
    output req_valid, req_data, req_rob_idx, req_rd, flush_valid, flush_mask,
    input  req_ready, grant,
    input  ex_out_valid, ex_out_data, ex_out_rob_idx, ex_out_rd,
    input  wb_out_valid, wb_out_data, wb_out_rob_idx, wb_out_rd
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates FU result ports onto one forwarding bus (ex_out_*) and a registered WB bus (wb_out_*).
// Latency: 0 cycles live input -> ex_out, 1 cycle -> wb_out; a losing port parks its result in a one-entry slot.
// Backpressure: req_ready[i] = slot i empty (pure register state). Ports: clk, rst (async, active-low), bus (slave).
// Build option WB_ARB_RR_EN: round-robin pointer replaces fixed priority with starvation escalation.
module wb_arbiter #(
  parameter int NUM_REQ    = 6,
  parameter int ROB_LEN    = 16,
  parameter int DATA_W     = 32,
  parameter int RD_W       = 7,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(ROB_LEN);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  rob_idx;
    logic [RD_W-1:0]   rd;
  } res_t;

  logic [NUM_REQ-1:0] hold_v_q, hold_v_d;
  res_t               hold_q [NUM_REQ];
  res_t               hold_d [NUM_REQ];
`ifndef WB_ARB_RR_EN
  logic [3:0]         age_q [NUM_REQ];
  logic [3:0]         age_d [NUM_REQ];
  logic [NUM_REQ-1:0] esc;
  logic [NUM_REQ-1:0] pick;
`else
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W:0]     scan;
`endif
  res_t               cand [NUM_REQ];
  logic [NUM_REQ-1:0] cand_v, kill, surv, gnt;
  logic [SEL_W-1:0]   gnt_idx;
  logic               win_v;
  res_t               win;
  logic               wb_v_q, wb_v_d;
  res_t               wb_q, wb_d;

  // Candidate selection, flush kill and arbitration.
  always_comb begin
    cand_v  = '0;
    kill    = '0;
    surv    = '0;
    gnt     = '0;
    gnt_idx = '0;
    win_v   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // A held result always takes precedence; a live input can only appear while the slot is empty.
      cand[i]   = hold_v_q[i] ? hold_q[i]
                              : {bus.req_data[i*DATA_W +: DATA_W],
                                 bus.req_rob_idx[i*IDX_W +: IDX_W],
                                 bus.req_rd[i*RD_W +: RD_W]};
      cand_v[i] = hold_v_q[i] | bus.req_valid[i];
      kill[i]   = cand_v[i] & bus.flush_valid & bus.flush_mask[cand[i].rob_idx];
      surv[i]   = cand_v[i] & ~kill[i];
    end
`ifndef WB_ARB_RR_EN
    esc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      esc[i] = hold_v_q[i] & surv[i] & (age_q[i] >= 4'(STARVE_MAX));
    end
    pick = (esc != '0) ? esc : surv;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        gnt_idx = SEL_W'(i);
        win_v   = 1'b1;
      end
    end
`else
    scan = '0;
    // Offsets scanned downwards so the nearest surviving port at/after the pointer wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (scan >= (SEL_W+1)'(NUM_REQ)) scan = scan - (SEL_W+1)'(NUM_REQ);
      if (surv[scan[SEL_W-1:0]]) begin
        gnt_idx = scan[SEL_W-1:0];
        win_v   = 1'b1;
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = win_v && (gnt_idx == SEL_W'(i));
    end
    win = win_v ? cand[gnt_idx] : '0;
  end

  // Hold slot / age / pointer next state.
  always_comb begin
    hold_v_d = hold_v_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      hold_d[i] = hold_q[i];
`ifndef WB_ARB_RR_EN
      age_d[i]  = age_q[i];
`endif
      if (gnt[i] || kill[i]) begin
        // Retired or squashed; a killed live input is simply never captured.
        hold_v_d[i] = 1'b0;
`ifndef WB_ARB_RR_EN
        age_d[i]    = 4'd0;
`endif
      end else if (cand_v[i] && !hold_v_q[i]) begin
        hold_v_d[i] = 1'b1;
        hold_d[i]   = cand[i];
`ifndef WB_ARB_RR_EN
        age_d[i]    = 4'd1;
`endif
      end else if (hold_v_q[i]) begin
`ifndef WB_ARB_RR_EN
        if (age_q[i] != 4'hf) age_d[i] = age_q[i] + 4'd1;
`endif
      end
    end
`ifdef WB_ARB_RR_EN
    ptr_d = ptr_q;
    if (win_v) ptr_d = (gnt_idx == SEL_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SEL_W'(1);
`endif
    wb_v_d = win_v;
    wb_d   = win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_v_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_q[i] <= '0;
`ifndef WB_ARB_RR_EN
        age_q[i]  <= '0;
`endif
      end
`ifdef WB_ARB_RR_EN
      ptr_q    <= '0;
`endif
      wb_v_q   <= 1'b0;
      wb_q     <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_q[i] <= hold_d[i];
`ifndef WB_ARB_RR_EN
        age_q[i]  <= age_d[i];
`endif
      end
`ifdef WB_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
      wb_v_q   <= wb_v_d;
      wb_q     <= wb_d;
    end
  end

  assign bus.req_ready      = ~hold_v_q;
  assign bus.grant          = gnt;
  assign bus.ex_out_valid   = win_v;
  assign bus.ex_out_data    = win.data;
  assign bus.ex_out_rob_idx = win.rob_idx;
  assign bus.ex_out_rd      = win.rd;
  assign bus.wb_out_valid   = wb_v_q;
  assign bus.wb_out_data    = wb_q.data;
  assign bus.wb_out_rob_idx = wb_q.rob_idx;
  assign bus.wb_out_rd      = wb_q.rd;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic against a behavioural writeback-arbiter model.
// Inputs change at the falling edge; outputs are sampled 1 time unit later, well away from the rising edge.
// Works for both the fixed-priority build and the WB_ARB_RR_EN build.
module tb_wb_arbiter;
  localparam int NUM_REQ = 6, ROB_LEN = 16, DATA_W = 32, RD_W = 7, STARVE_MAX = 4, IDX_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  wb_arbiter_if #(.NUM_REQ(NUM_REQ), .ROB_LEN(ROB_LEN), .DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  wb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_LEN(ROB_LEN), .DATA_W(DATA_W), .RD_W(RD_W),
               .STARVE_MAX(STARVE_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle();
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_rob_idx = '0;
    bus.req_rd      = '0;
    bus.flush_valid = 1'b0;
    bus.flush_mask  = '0;
  endtask

  task automatic set_req(input int p, input logic [31:0] d, input logic [3:0] idx, input logic [6:0] rd);
    bus.req_valid[p]                    = 1'b1;
    bus.req_data[p*DATA_W +: DATA_W]    = d;
    bus.req_rob_idx[p*IDX_W +: IDX_W]   = idx;
    bus.req_rd[p*RD_W +: RD_W]          = rd;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #12;
    total++; if (bus.wb_out_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b want=0", bus.wb_out_valid); end
    total++; if (bus.wb_out_data !== 32'h0) begin bad++; $display("FAIL rst_wb_data got=%h want=0", bus.wb_out_data); end
    total++; if (bus.req_ready !== 6'b111111) begin bad++; $display("FAIL rst_ready got=%b want=111111", bus.req_ready); end
    total++; if (bus.grant !== 6'b0) begin bad++; $display("FAIL rst_grant got=%b want=0", bus.grant); end
    total++; if (bus.ex_out_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%b want=0", bus.ex_out_valid); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk); idle(); set_req(2, 32'h1234, 4'd3, 7'd9); #1;
    total++; if (bus.grant !== 6'b000100) begin bad++; $display("FAIL single_grant got=%b want=000100", bus.grant); end
    total++; if (bus.ex_out_valid !== 1'b1) begin bad++; $display("FAIL single_ex_valid got=%b want=1", bus.ex_out_valid); end
    total++; if (bus.ex_out_data !== 32'h1234) begin bad++; $display("FAIL single_ex_data got=%h want=1234", bus.ex_out_data); end
    total++; if (bus.ex_out_rob_idx !== 4'd3) begin bad++; $display("FAIL single_ex_rob got=%0d want=3", bus.ex_out_rob_idx); end
    total++; if (bus.ex_out_rd !== 7'd9) begin bad++; $display("FAIL single_ex_rd got=%0d want=9", bus.ex_out_rd); end
    @(negedge clk); idle(); #1;
    total++; if (bus.wb_out_valid !== 1'b1) begin bad++; $display("FAIL single_wb_valid got=%b want=1", bus.wb_out_valid); end
    total++; if (bus.wb_out_data !== 32'h1234) begin bad++; $display("FAIL single_wb_data got=%h want=1234", bus.wb_out_data); end
    total++; if (bus.wb_out_rob_idx !== 4'd3) begin bad++; $display("FAIL single_wb_rob got=%0d want=3", bus.wb_out_rob_idx); end
    total++; if (bus.wb_out_rd !== 7'd9) begin bad++; $display("FAIL single_wb_rd got=%0d want=9", bus.wb_out_rd); end
    total++; if (bus.req_ready[2] !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", bus.req_ready[2]); end
    total++; if (bus.ex_out_data !== 32'h0) begin bad++; $display("FAIL idle_ex_data got=%h want=0", bus.ex_out_data); end
  endtask

  task automatic test_two_ports();
    @(negedge clk); idle(); set_req(0, 32'h0a0a, 4'd1, 7'd11); set_req(3, 32'h0b0b, 4'd2, 7'd12); #1;
    total++; if (bus.grant !== 6'b000001) begin bad++; $display("FAIL two_grant0 got=%b want=000001", bus.grant); end
    total++; if (bus.ex_out_data !== 32'h0a0a) begin bad++; $display("FAIL two_data0 got=%h want=0a0a", bus.ex_out_data); end
    @(negedge clk); idle(); #1;
    total++; if (bus.req_ready !== 6'b110111) begin bad++; $display("FAIL two_ready got=%b want=110111", bus.req_ready); end
    total++; if (bus.grant !== 6'b001000) begin bad++; $display("FAIL two_grant3 got=%b want=001000", bus.grant); end
    total++; if (bus.ex_out_data !== 32'h0b0b) begin bad++; $display("FAIL two_data3 got=%h want=0b0b", bus.ex_out_data); end
    @(negedge clk); idle(); #1;
    total++; if (bus.req_ready !== 6'b111111) begin bad++; $display("FAIL two_drained got=%b want=111111", bus.req_ready); end
  endtask

`ifndef WB_ARB_RR_EN
  task automatic test_starve();
    @(negedge clk); idle(); set_req(0, 32'h100, 4'd0, 7'd1); set_req(4, 32'h4444, 4'd4, 7'd44); #1;
    total++; if (bus.grant !== 6'b000001) begin bad++; $display("FAIL starve_first got=%b want=000001", bus.grant); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); idle(); set_req(0, 32'h100 + 32'(c), 4'd0, 7'd1); #1;
      if (c < 4) begin
        total++; if (bus.grant !== 6'b000001) begin bad++; $display("FAIL starve_wait%0d got=%b want=000001", c, bus.grant); end
      end else begin
        total++; if (bus.grant !== 6'b010000) begin bad++; $display("FAIL starve_esc got=%b want=010000", bus.grant); end
        total++; if (bus.ex_out_data !== 32'h4444) begin bad++; $display("FAIL starve_esc_data got=%h want=4444", bus.ex_out_data); end
      end
    end
    @(negedge clk); idle(); #1;
    total++; if (bus.grant !== 6'b000001) begin bad++; $display("FAIL starve_p0_next got=%b want=000001", bus.grant); end
    total++; if (bus.ex_out_data !== 32'h104) begin bad++; $display("FAIL starve_p0_data got=%h want=104", bus.ex_out_data); end
    @(negedge clk); idle(); #1;
    total++; if (bus.grant !== 6'b0) begin bad++; $display("FAIL starve_drained got=%b want=0", bus.grant); end
  endtask
`endif

  task automatic test_flush();
    // Park rob=5 in port 1, then flush it while port 2 (rob=6) is live.
    @(negedge clk); idle(); set_req(0, 32'h1, 4'd0, 7'd1); set_req(1, 32'h5555, 4'd5, 7'd15);
    @(negedge clk); idle(); bus.flush_valid = 1'b1; bus.flush_mask = 16'h0020; set_req(2, 32'h6666, 4'd6, 7'd16); #1;
    total++; if (bus.grant !== 6'b000100) begin bad++; $display("FAIL flush_live_grant got=%b want=000100", bus.grant); end
    total++; if (bus.ex_out_rob_idx !== 4'd6) begin bad++; $display("FAIL flush_live_rob got=%0d want=6", bus.ex_out_rob_idx); end
    @(negedge clk); idle(); #1;
    total++; if (bus.req_ready !== 6'b111111) begin bad++; $display("FAIL flush_cleared got=%b want=111111", bus.req_ready); end
    total++; if (bus.grant !== 6'b0) begin bad++; $display("FAIL flush_no_stale got=%b want=0", bus.grant); end
    // Flush alone kills both a held slot and a live input with the same rob index.
    @(negedge clk); idle(); set_req(0, 32'h1, 4'd0, 7'd1); set_req(1, 32'h5555, 4'd5, 7'd15);
    @(negedge clk); idle(); bus.flush_valid = 1'b1; bus.flush_mask = 16'h0020; set_req(3, 32'h7777, 4'd5, 7'd17); #1;
    total++; if (bus.grant !== 6'b0) begin bad++; $display("FAIL flush_only_grant got=%b want=0", bus.grant); end
    total++; if (bus.ex_out_valid !== 1'b0) begin bad++; $display("FAIL flush_only_ex got=%b want=0", bus.ex_out_valid); end
    @(negedge clk); idle(); #1;
    total++; if (bus.req_ready !== 6'b111111) begin bad++; $display("FAIL flush_only_ready got=%b want=111111", bus.req_ready); end
    total++; if (bus.ex_out_valid !== 1'b0) begin bad++; $display("FAIL flush_not_captured got=%b want=0", bus.ex_out_valid); end
    total++; if (bus.wb_out_valid !== 1'b0) begin bad++; $display("FAIL flush_wb got=%b want=0", bus.wb_out_valid); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle();
    for (int i = 0; i < 4; i++) set_req(i, 32'h900 + 32'(i), 4'(i + 8), 7'(i));
    @(negedge clk); idle(); #1;
    total++; if ($countones(bus.req_ready) !== 3) begin bad++; $display("FAIL arst_held got=%b want=three_held", bus.req_ready); end
    total++; if (bus.wb_out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_wb got=%b want=1", bus.wb_out_valid); end
    #1; rst = 1'b0; #1;
    total++; if (bus.wb_out_valid !== 1'b0) begin bad++; $display("FAIL arst_wb got=%b want=0", bus.wb_out_valid); end
    total++; if (bus.req_ready !== 6'b111111) begin bad++; $display("FAIL arst_ready got=%b want=111111", bus.req_ready); end
    total++; if (bus.grant !== 6'b0) begin bad++; $display("FAIL arst_grant got=%b want=0", bus.grant); end
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      total++; if (bus.ex_out_valid !== 1'b0 || bus.wb_out_valid !== 1'b0) begin
        bad++; $display("FAIL arst_stale%0d got=ex%b/wb%b want=0/0", c, bus.ex_out_valid, bus.wb_out_valid);
      end
    end
  endtask

`ifdef WB_ARB_RR_EN
  task automatic test_rr();
    logic [NUM_REQ-1:0] exp_g;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); idle();
      for (int i = 0; i < 3; i++) if (bus.req_ready[i]) set_req(i, 32'(c * 16 + i), 4'(i), 7'(i));
      #1;
      exp_g = '0; exp_g[c % 3] = 1'b1;
      total++; if (bus.grant !== exp_g) begin bad++; $display("FAIL rr_rotate%0d got=%b want=%b", c, bus.grant, exp_g); end
    end
    repeat (4) begin @(negedge clk); idle(); end
  endtask
`endif

  task automatic test_random();
    logic        m_hv [NUM_REQ];
    logic [31:0] m_d  [NUM_REQ];
    logic [3:0]  m_i  [NUM_REQ];
    logic [6:0]  m_r  [NUM_REQ];
    int          m_age[NUM_REQ];
    int          m_ptr;
    logic        lv [NUM_REQ];
    logic [31:0] ld [NUM_REQ];
    logic [3:0]  li [NUM_REQ];
    logic [6:0]  lr [NUM_REQ];
    logic        cv [NUM_REQ];
    logic        alive [NUM_REQ];
    logic [3:0]  ci;
    logic        fv;
    logic [15:0] fm;
    int          win;
    logic [NUM_REQ-1:0] exp_g, exp_rdy;
    logic        pv, ev;
    logic [31:0] pd, ed;
    logic [3:0]  pi, ei;
    logic [6:0]  pr, er;

    @(negedge clk); idle(); rst = 1'b0; #2; rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin m_hv[i] = 1'b0; m_age[i] = 0; end
    m_ptr = 0; pv = 1'b0; pd = '0; pi = '0; pr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        total++; if (bus.wb_out_valid !== pv || bus.wb_out_data !== pd || bus.wb_out_rob_idx !== pi || bus.wb_out_rd !== pr) begin
          bad++; $display("FAIL rnd_wb cyc=%0d got=%b/%h/%0d/%0d want=%b/%h/%0d/%0d", cyc, bus.wb_out_valid,
                          bus.wb_out_data, bus.wb_out_rob_idx, bus.wb_out_rd, pv, pd, pi, pr);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) exp_rdy[i] = !m_hv[i];
      total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, bus.req_ready, exp_rdy); end
      idle();
      for (int i = 0; i < NUM_REQ; i++) begin
        lv[i] = !m_hv[i] && ($urandom_range(0, 2) != 0);
        ld[i] = $urandom; li[i] = 4'($urandom_range(0, 15)); lr[i] = 7'($urandom_range(0, 127));
        if (lv[i]) set_req(i, ld[i], li[i], lr[i]);
      end
      fv = ($urandom_range(0, 3) == 0);
      fm = 16'($urandom);
      bus.flush_valid = fv; bus.flush_mask = fm;
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        cv[i]    = m_hv[i] || lv[i];
        ci       = m_hv[i] ? m_i[i] : li[i];
        alive[i] = cv[i] && !(fv && fm[ci]);
      end
      win = -1;
`ifndef WB_ARB_RR_EN
      for (int i = 0; i < NUM_REQ; i++) if (win < 0 && alive[i] && m_hv[i] && m_age[i] >= STARVE_MAX) win = i;
      for (int i = 0; i < NUM_REQ; i++) if (win < 0 && alive[i]) win = i;
`else
      for (int k = 0; k < NUM_REQ; k++) if (win < 0 && alive[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
`endif
      exp_g = '0; ev = 1'b0; ed = '0; ei = '0; er = '0;
      if (win >= 0) begin
        exp_g[win] = 1'b1; ev = 1'b1;
        ed = m_hv[win] ? m_d[win] : ld[win];
        ei = m_hv[win] ? m_i[win] : li[win];
        er = m_hv[win] ? m_r[win] : lr[win];
      end
      total++; if (bus.grant !== exp_g) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", cyc, bus.grant, exp_g); end
      total++; if (bus.ex_out_valid !== ev || bus.ex_out_data !== ed || bus.ex_out_rob_idx !== ei || bus.ex_out_rd !== er) begin
        bad++; $display("FAIL rnd_ex cyc=%0d got=%b/%h/%0d/%0d want=%b/%h/%0d/%0d", cyc, bus.ex_out_valid,
                        bus.ex_out_data, bus.ex_out_rob_idx, bus.ex_out_rd, ev, ed, ei, er);
      end
      pv = ev; pd = ed; pi = ei; pr = er;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == win || (cv[i] && !alive[i])) begin
          m_hv[i] = 1'b0; m_age[i] = 0;
        end else if (lv[i]) begin
          m_hv[i] = 1'b1; m_d[i] = ld[i]; m_i[i] = li[i]; m_r[i] = lr[i]; m_age[i] = 1;
        end else if (m_hv[i]) begin
          m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
        end
      end
      if (win >= 0) m_ptr = (win + 1) % NUM_REQ;
    end
    @(negedge clk); idle(); #1;
    total++; if (bus.wb_out_valid !== pv || bus.wb_out_data !== pd) begin
      bad++; $display("FAIL rnd_wb_last got=%b/%h want=%b/%h", bus.wb_out_valid, bus.wb_out_data, pv, pd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_ports();
`ifndef WB_ARB_RR_EN
    test_starve();
`endif
    test_flush();
    test_async_reset();
`ifdef WB_ARB_RR_EN
    test_rr();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
